// File: rtl/lcd_snapshot_ctrl.sv
// Step/snapshot controller feeding the character-LCD stage: debounced single-step of the CPU,
// capture of CPU state into display registers and an active-low LOAD restart strobe.
module lcd_snapshot_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned STEP_W     = 4,
    parameter int unsigned SETTLE     = 8,
    parameter int unsigned LOAD_W     = 16,
    parameter int unsigned REFRESH    = 5000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        KEY_STEP,
    input  logic        SW_RUN,
    input  logic [31:0] CPU_DATA,
    input  logic [31:0] CPU_PC,
    input  logic [7:0]  CPU_SEL,
    output logic        STEP_CLK,
    output logic [31:0] DATA,
    output logic [31:0] PC,
    output logic [7:0]  SEL,
    output logic        LOAD,
    output logic        BUSY
);

    localparam int unsigned DW    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RW    = $clog2(REFRESH + 1);
    localparam int unsigned TMAX1 = (STEP_W > SETTLE) ? STEP_W : SETTLE;
    localparam int unsigned TMAX  = (TMAX1 > LOAD_W) ? TMAX1 : LOAD_W;
    localparam int unsigned TW    = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] REF_LAST    = RW'(REFRESH - 1);
    localparam logic [TW-1:0] STEP_LAST   = TW'(STEP_W - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] LOAD_LAST   = TW'(LOAD_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStepHi,
        StStepLo,
        StCapture,
        StLoadPulse,
        StWaitRel
    } state_e;

    state_e          state_q;
    logic [TW-1:0]   tmr_q;
    logic            key_meta_q, key_sync_q;
    logic            run_meta_q, run_sync_q;
    logic [DW-1:0]   deb_cnt_q;
    logic            key_deb_q;
    logic            press_q;
    logic [RW-1:0]   refresh_cnt_q;
    logic            refresh_hit;

    // Key idles released (1); run switch idles in manual mode (0).
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            run_meta_q <= 1'b0;
            run_sync_q <= 1'b0;
        end else begin
            key_meta_q <= KEY_STEP;
            key_sync_q <= key_meta_q;
            run_meta_q <= SW_RUN;
            run_sync_q <= run_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            deb_cnt_q <= '0;
            key_deb_q <= 1'b1;
            press_q   <= 1'b0;
        end else if (key_sync_q == key_deb_q) begin
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            key_deb_q <= key_sync_q;
            press_q   <= ~key_sync_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
            press_q   <= 1'b0;
        end
    end

    assign refresh_hit = (refresh_cnt_q == REF_LAST);

    // Holds its count while a sequence is in flight; only idle time counts toward a refresh.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            refresh_cnt_q <= '0;
        end else if (!run_sync_q) begin
            refresh_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            refresh_cnt_q <= refresh_hit ? '0 : refresh_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            tmr_q    <= '0;
            STEP_CLK <= 1'b0;
            LOAD     <= 1'b1;
            BUSY     <= 1'b0;
            DATA     <= '0;
            PC       <= '0;
            SEL      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!run_sync_q && press_q) begin
                        state_q  <= StStepHi;
                        tmr_q    <= STEP_LAST;
                        STEP_CLK <= 1'b1;
                        BUSY     <= 1'b1;
                    end else if (run_sync_q && refresh_hit) begin
                        state_q <= StCapture;
                        BUSY    <= 1'b1;
                    end
                end
                StStepHi: begin
                    if (tmr_q == '0) begin
                        state_q  <= StStepLo;
                        tmr_q    <= SETTLE_LAST;
                        STEP_CLK <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                StStepLo: begin
                    if (tmr_q == '0) begin
                        state_q <= StCapture;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                StCapture: begin
                    // LOAD falls on the same edge the snapshot lands, so the display sees stable data.
                    DATA    <= CPU_DATA;
                    PC      <= CPU_PC;
                    SEL     <= CPU_SEL;
                    LOAD    <= 1'b0;
                    tmr_q   <= LOAD_LAST;
                    state_q <= StLoadPulse;
                end
                StLoadPulse: begin
                    if (tmr_q == '0) begin
                        LOAD    <= 1'b1;
                        state_q <= StWaitRel;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                StWaitRel: begin
                    if (key_deb_q) begin
                        state_q <= StIdle;
                        BUSY    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_snapshot_ctrl.sv
// Self-checking bench for lcd_snapshot_ctrl: table-driven manual steps, bounce rejection,
// run-mode refresh and reset mid-pulse, with a snapshot scoreboard popped on each LOAD fall.
module tb_lcd_snapshot_ctrl;

    localparam int unsigned DEB_CYCLES = 4;
    localparam int unsigned STEP_W     = 2;
    localparam int unsigned SETTLE     = 3;
    localparam int unsigned LOAD_W     = 5;
    localparam int unsigned REFRESH    = 50;
    // Key drop -> LOAD fall: 2 sync + debounce + (1 + STEP_W + SETTLE + 1).
    localparam int LATENCY = 2 + DEB_CYCLES + 1 + STEP_W + SETTLE + 1;
    localparam int PERIOD  = REFRESH + 1 + LOAD_W + 1;

    logic        CLOCK_50 = 1'b0;
    logic        RESET    = 1'b1;
    logic        KEY_STEP = 1'b1;
    logic        SW_RUN   = 1'b0;
    logic [31:0] CPU_DATA = '0;
    logic [31:0] CPU_PC   = '0;
    logic [7:0]  CPU_SEL  = '0;
    logic        STEP_CLK;
    logic [31:0] DATA;
    logic [31:0] PC;
    logic [7:0]  SEL;
    logic        LOAD;
    logic        BUSY;

    lcd_snapshot_ctrl #(
        .DEB_CYCLES (DEB_CYCLES),
        .STEP_W     (STEP_W),
        .SETTLE     (SETTLE),
        .LOAD_W     (LOAD_W),
        .REFRESH    (REFRESH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .KEY_STEP (KEY_STEP),
        .SW_RUN   (SW_RUN),
        .CPU_DATA (CPU_DATA),
        .CPU_PC   (CPU_PC),
        .CPU_SEL  (CPU_SEL),
        .STEP_CLK (STEP_CLK),
        .DATA     (DATA),
        .PC       (PC),
        .SEL      (SEL),
        .LOAD     (LOAD),
        .BUSY     (BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic [7:0]  sel;
    } snap_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic [7:0]  sel;
        int          hold;
        int          exp_steps;
        int          exp_loads;
    } vec_t;

    snap_t sb[$];
    snap_t mon_exp;
    vec_t  vecs[3];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int step_rises = 0;
    int load_falls = 0;
    int step_hi = 0;
    int load_lo = 0;
    int load_fall_cyc = 0;
    logic step_prev = 1'b0;
    logic load_prev = 1'b1;
    bit width_chk = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        cyc++;
        if (STEP_CLK && !step_prev) begin
            step_rises++;
            step_hi = 0;
        end
        if (STEP_CLK) step_hi++;
        if (!STEP_CLK && step_prev && width_chk) check("step_width", step_hi, STEP_W);
        if (!LOAD && load_prev) begin
            load_falls++;
            load_fall_cyc = cyc;
            load_lo = 0;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got a LOAD pulse, expected none");
            end else begin
                mon_exp = sb.pop_front();
                check("snap_data", DATA, mon_exp.data);
                check("snap_pc", PC, mon_exp.pc);
                check("snap_sel", SEL, mon_exp.sel);
            end
        end
        if (!LOAD) load_lo++;
        if (LOAD && !load_prev && width_chk) check("load_width", load_lo, LOAD_W);
        step_prev = STEP_CLK;
        load_prev = LOAD;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_fall(input int f0, input int bound, input string name);
        int n = 0;
        while (load_falls == f0 && n < bound) begin
            tick();
            n++;
        end
        check(name, 64'(load_falls != f0), 64'd1);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (BUSY && n < bound) begin
            tick();
            n++;
        end
        check(name, 64'(BUSY), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int s0, f0, a, n;
        int fall_t[4];

        vecs[0] = '{data: 32'hDEAD_BEEF, pc: 32'h0000_0010, sel: 8'h3A, hold: 20,
                    exp_steps: 1, exp_loads: 1};
        vecs[1] = '{data: 32'h0123_4567, pc: 32'h0040_0020, sel: 8'h05, hold: 200,
                    exp_steps: 1, exp_loads: 1};
        vecs[2] = '{data: 32'h0000_0000, pc: 32'hFFFF_FFFC, sel: 8'hFF, hold: 35,
                    exp_steps: 1, exp_loads: 1};

        repeat (3) tick();
        check("rst_step_clk", STEP_CLK, 0);
        check("rst_data", DATA, 0);
        check("rst_pc", PC, 0);
        check("rst_sel", SEL, 0);
        check("rst_load", LOAD, 1);
        check("rst_busy", BUSY, 0);
        RESET = 1'b0;
        repeat (5) tick();

        // Manual step vectors: one step and one snapshot per press, whatever the hold time.
        for (int i = 0; i < 3; i++) begin
            CPU_DATA = vecs[i].data;
            CPU_PC   = vecs[i].pc;
            CPU_SEL  = vecs[i].sel;
            sb.push_back('{data: vecs[i].data, pc: vecs[i].pc, sel: vecs[i].sel});
            s0 = step_rises;
            f0 = load_falls;
            a  = cyc;
            KEY_STEP = 1'b0;
            repeat (vecs[i].hold) tick();
            check("busy_wait_rel", BUSY, 1);
            check("load_latency", load_fall_cyc - (a + 1), LATENCY);
            KEY_STEP = 1'b1;
            wait_idle(40, "release_idle");
            check("step_count", step_rises - s0, vecs[i].exp_steps);
            check("load_count", load_falls - f0, vecs[i].exp_loads);
            CPU_DATA = ~vecs[i].data;
            CPU_PC   = ~vecs[i].pc;
            repeat (6) tick();
            check("data_hold", DATA, vecs[i].data);
            check("pc_hold", PC, vecs[i].pc);
            repeat (4) tick();
        end

        // Bounce: lows of 2 cycles never survive the debounce window.
        s0 = step_rises;
        f0 = load_falls;
        for (int i = 0; i < 10; i++) begin
            KEY_STEP = ~KEY_STEP;
            repeat (2) tick();
        end
        KEY_STEP = 1'b1;
        repeat (20) tick();
        check("bounce_steps", step_rises - s0, 0);
        check("bounce_loads", load_falls - f0, 0);
        check("bounce_load_level", LOAD, 1);
        check("bounce_busy", BUSY, 0);

        // Run mode: periodic snapshots, key presses ignored.
        s0 = step_rises;
        CPU_DATA = 32'h1111_0000;
        sb.push_back('{data: CPU_DATA, pc: CPU_PC, sel: CPU_SEL});
        SW_RUN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f0 = load_falls;
            wait_fall(f0, PERIOD + 20, "run_refresh");
            fall_t[k] = load_fall_cyc;
            if (k > 0) check("run_period", fall_t[k] - fall_t[k-1], PERIOD);
            CPU_DATA = 32'h1111_0000 + 32'(k + 1);
            if (k < 3) sb.push_back('{data: CPU_DATA, pc: CPU_PC, sel: CPU_SEL});
            repeat (9) tick();
            KEY_STEP = 1'b0;
            repeat (8) tick();
            KEY_STEP = 1'b1;
        end
        SW_RUN = 1'b0;
        repeat (4) tick();
        wait_idle(40, "run_exit_idle");
        check("run_no_step", step_rises - s0, 0);
        check("run_queue_empty", sb.size(), 0);
        repeat (60) tick();
        check("run_off_no_refresh", sb.size(), 0);

        // Reset during the second LOAD-low cycle.
        s0 = step_rises;
        f0 = load_falls;
        CPU_DATA = 32'hCAFE_F00D;
        CPU_PC   = 32'h0000_0024;
        CPU_SEL  = 8'h05;
        sb.push_back('{data: CPU_DATA, pc: CPU_PC, sel: CPU_SEL});
        KEY_STEP = 1'b0;
        n = 0;
        while (LOAD && n < 40) begin
            tick();
            n++;
        end
        check("pulse_started", LOAD, 0);
        tick();
        check("pulse_cycle2", LOAD, 0);
        width_chk = 1'b0;
        #2 RESET = 1'b1;
        #1;
        check("midrst_load", LOAD, 1);
        check("midrst_step_clk", STEP_CLK, 0);
        check("midrst_data", DATA, 0);
        check("midrst_pc", PC, 0);
        check("midrst_sel", SEL, 0);
        check("midrst_busy", BUSY, 0);
        KEY_STEP = 1'b1;
        repeat (3) tick();
        check("midrst_load_held", LOAD, 1);
        RESET = 1'b0;
        repeat (30) tick();
        check("post_rst_loads", load_falls - f0, 1);
        check("post_rst_steps", step_rises - s0, 1);
        check("post_rst_load_level", LOAD, 1);
        check("post_rst_busy", BUSY, 0);
        width_chk = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
